// File: rtl/fifo_rd_packer_pkg.sv
// Shared types and helpers for the FIFO read-side packer.
package fifo_rd_packer_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/rd_idle_timer.sv
// Saturating idle counter; expired_o is high once MAX idle cycles have been counted.
module rd_idle_timer
   import fifo_rd_packer_pkg::*;
#(
   parameter int MAX = 8
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int W = clog2(MAX + 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)                             cnt_d = '0;
      else if (en_i && (cnt_q != W'(MAX)))   cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign expired_o = (cnt_q == W'(MAX));

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops narrow FIFO entries and packs PACK_RATIO of them into one wide word,
// flushing a partial word after TIMEOUT_CYCLES idle cycles.
module fifo_rd_packer
   import fifo_rd_packer_pkg::*;
#(
   parameter  int DATA_WIDTH     = 4,
   parameter  int PACK_RATIO     = 4,
   parameter  int TIMEOUT_CYCLES = 8,
   localparam int CNT_W          = clog2(PACK_RATIO + 1)
) (
   input  logic                             rd_clk_in,
   input  logic                             rst_n_rd_in,
   input  logic [DATA_WIDTH-1:0]            data_in,
   input  logic                             empty_in,
   input  logic                             almost_empty_in,
   output logic                             pop_out,
   output logic [DATA_WIDTH*PACK_RATIO-1:0] word_out,
   output logic [CNT_W-1:0]                 word_cnt_out,
   output logic                             word_valid_out,
   input  logic                             word_ready_in
);

   localparam int LANE_W = clog2(PACK_RATIO);

   state_e                                 state_q;
   logic [CNT_W-1:0]                       fill_q;
   logic [CNT_W-1:0]                       cnt_q;
   logic                                   pop_q;
   logic [PACK_RATIO-1:0][DATA_WIDTH-1:0]  lanes_q;

   logic expired, flush, tmr_clr, tmr_en;

   // Flush wins over a late pop so no entry is ever in flight while holding.
   assign flush   = (state_q == ACCUM) && (fill_q != '0) && !pop_q && expired;
   assign pop_out = (state_q == ACCUM) && !empty_in && !(almost_empty_in && pop_q) &&
                    ((fill_q + CNT_W'(pop_q)) < CNT_W'(PACK_RATIO)) && !flush;

   assign tmr_clr = ((state_q == ACCUM) && pop_q) || ((state_q == HOLD) && word_ready_in);
   assign tmr_en  = (state_q == ACCUM) && (fill_q != '0) && !pop_q;

   rd_idle_timer #(.MAX(TIMEOUT_CYCLES)) u_idle (
      .clk_i     (rd_clk_in),
      .rst_n_i   (rst_n_rd_in),
      .clr_i     (tmr_clr),
      .en_i      (tmr_en),
      .expired_o (expired)
   );

   always_ff @(posedge rd_clk_in or negedge rst_n_rd_in) begin
      if (!rst_n_rd_in) begin
         state_q <= ACCUM;
         fill_q  <= '0;
         cnt_q   <= '0;
         pop_q   <= 1'b0;
         lanes_q <= '0;
      end else begin
         pop_q <= pop_out;
         case (state_q)
            ACCUM: begin
               if (pop_q) begin
                  lanes_q[fill_q[LANE_W-1:0]] <= data_in;
                  fill_q <= fill_q + CNT_W'(1);
                  if (fill_q == CNT_W'(PACK_RATIO - 1)) begin
                     state_q <= HOLD;
                     cnt_q   <= CNT_W'(PACK_RATIO);
                  end
               end else if (flush) begin
                  state_q <= HOLD;
                  cnt_q   <= fill_q;
               end
            end
            HOLD: begin
               if (word_ready_in) begin
                  state_q <= ACCUM;
                  fill_q  <= '0;
                  cnt_q   <= '0;
                  lanes_q <= '0;
               end
            end
            default: state_q <= ACCUM;
         endcase
      end
   end

   assign word_out       = lanes_q;
   assign word_cnt_out   = cnt_q;
   assign word_valid_out = (state_q == HOLD);

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: FIFO model, abstract packing model, word scoreboard.
module tb_fifo_rd_packer;
   localparam int DW = 4, PR = 4, TO = 8, CW = 3, WW = DW * PR;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] data_in;
   logic          empty_in, aempty_in, pop_out;
   logic [WW-1:0] word_out;
   logic [CW-1:0] word_cnt_out;
   logic          word_valid_out, word_ready_in;

   always #5 clk = ~clk;

   fifo_rd_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR), .TIMEOUT_CYCLES(TO)) dut (
      .rd_clk_in       (clk),
      .rst_n_rd_in     (rst_n),
      .data_in         (data_in),
      .empty_in        (empty_in),
      .almost_empty_in (aempty_in),
      .pop_out         (pop_out),
      .word_out        (word_out),
      .word_cnt_out    (word_cnt_out),
      .word_valid_out  (word_valid_out),
      .word_ready_in   (word_ready_in)
   );

   typedef struct {
      logic [WW-1:0] w;
      int            cnt;
      int            cyc;
   } exp_t;

   int            checks = 0, errors = 0;
   int            cyc = 0;
   exp_t          sb[$];
   logic [DW-1:0] fq[$];

   // model state: words in hold, entries collected, read in flight, quiet edges
   bit            m_hold, m_fly;
   int            m_cnt, m_quiet;
   logic [DW-1:0] acc[PR];
   logic [DW-1:0] cap_d;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void upd_flags();
      empty_in  = (fq.size() == 0);
      aempty_in = (fq.size() == 1);
   endfunction

   task automatic push(input logic [DW-1:0] d);
      fq.push_back(d);
      upd_flags();
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   function automatic void mreset();
      m_hold = 0; m_fly = 0; m_cnt = 0; m_quiet = 0;
      fq.delete();
      sb.delete();
      upd_flags();
   endfunction

   function automatic void close_word();
      exp_t e;
      e.w = '0;
      for (int i = 0; i < m_cnt; i++) e.w[i*DW +: DW] = acc[i];
      e.cnt = m_cnt;
      e.cyc = cyc;
      sb.push_back(e);
      m_hold = 1;
   endfunction

   // FIFO model plus packing model: a word closes when PR entries are
   // collected, or after TO+1 quiet edges following the last capture.
   initial begin : model
      bit p, hs, to, ep;
      data_in = '0;
      mreset();
      forever begin
         @(negedge clk);
         if (!rst_n) begin mreset(); continue; end
         to = !m_hold && (m_cnt > 0) && !m_fly && (m_quiet >= TO);
         ep = !m_hold && !empty_in && !(aempty_in && m_fly) &&
              ((m_cnt + int'(m_fly)) < PR) && !to;
         chk("pop_out", pop_out, ep);
         chk("valid", word_valid_out, m_hold);
         p  = pop_out;
         hs = m_hold && word_ready_in;
         @(posedge clk); #1;
         if (!rst_n) begin mreset(); continue; end
         if (m_hold) begin
            if (hs) begin m_hold = 0; m_cnt = 0; m_quiet = 0; end
         end else if (m_fly) begin
            acc[m_cnt] = cap_d;
            m_cnt++;
            m_quiet = 0;
            if (m_cnt == PR) close_word();
         end else if (to) begin
            close_word();
         end else if (m_cnt > 0 && m_quiet < TO) begin
            m_quiet++;
         end
         m_fly = p;
         if (p) begin
            if (fq.size() > 0) data_in = fq.pop_front();
            else               data_in = 'x;
            cap_d = data_in;
            upd_flags();
         end
      end
   end

   initial begin : monitor
      bit            pv;
      logic [WW-1:0] hw;
      logic [CW-1:0] hc;
      exp_t          e;
      pv = 0; hw = '0; hc = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin pv = 0; continue; end
         if (word_valid_out && !pv) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_word: got %0h expected none (cycle %0d)", word_out, cyc);
            end else begin
               e = sb.pop_front();
               chk("word", word_out, e.w);
               chk("word_cnt", word_cnt_out, e.cnt);
               chk("word_cycle", cyc, e.cyc);
            end
            hw = word_out;
            hc = word_cnt_out;
         end else if (word_valid_out) begin
            chk("hold_word", word_out, hw);
            chk("hold_cnt", word_cnt_out, hc);
         end
         pv = word_valid_out && !word_ready_in;
      end
   end

   task automatic do_reset();
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("rst_word", word_out, 0);
      chk("rst_cnt", word_cnt_out, 0);
      chk("rst_valid", word_valid_out, 0);
      step(2);
      rst_n = 1'b1;
   endtask

   initial begin : stim
      bit seen;
      rst_n = 1'b0;
      word_ready_in = 1'b1;
      #3;
      chk("init_word", word_out, 0);
      chk("init_valid", word_valid_out, 0);
      step(2);
      rst_n = 1'b1;

      for (int i = 1; i <= 4; i++) push(4'(i));
      step(15);

      word_ready_in = 1'b0;
      for (int i = 1; i <= 8; i++) push(4'(i));
      step(16);
      word_ready_in = 1'b1;
      step(15);

      push(4'hA);
      step(20);
      push(4'hA); push(4'hB);
      step(20);

      for (int d = 5; d <= 11; d++) begin
         push(4'(d));
         step(d);
         push(4'(d + 1));
         step(25);
      end

      word_ready_in = 1'b0;
      for (int i = 1; i <= 4; i++) push(4'(i + 8));
      step(10);
      do_reset();
      for (int i = 0; i < 4; i++) push(4'(i + 12));
      word_ready_in = 1'b1;
      step(15);

      for (int i = 0; i < 3; i++) push(4'(i + 5));
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (pop_out) seen = 1;
      end
      chk("pop_seen", seen, 1);
      do_reset();
      for (int i = 0; i < 4; i++) push(4'(i + 1));
      step(15);

      for (int i = 0; i < 800; i++) begin
         if (fq.size() < 12) begin
            if ((i % 200) < 120) begin
               if ($urandom_range(0, 1) == 0) push(4'($urandom));
            end else if ($urandom_range(0, 11) == 0) begin
               push(4'($urandom));
            end
         end
         word_ready_in = ($urandom_range(0, 3) != 0);
         step(1);
      end

      word_ready_in = 1'b1;
      step(60);
      chk("fifo_drained", fq.size(), 0);
      chk("sb_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
